// File: rtl/fetch_inst_queue.sv
// Circular instruction queue between fetch and decode/dispatch; flushes on branch mispredict.
// Optional same-cycle enq->deq bypass when empty: define FETCH_Q_BYPASS_EN.
module fetch_inst_queue #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_mispredict,
  input  logic             enq_valid,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_pc_next,
  input  logic [63:0]      enq_order,
  input  logic             enq_br_pred,
  output logic             is_fetch_q_full,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [31:0]      deq_inst,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_pc_next,
  output logic [63:0]      deq_order,
  output logic             deq_br_pred,
  output logic [PTR_W-1:0] q_count
);

  localparam int IDX_W   = PTR_W - 1;
  localparam int ENTRY_W = 32 + 32 + 32 + 64 + 1;

  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [IDX_W-1:0]   widx, ridx;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] enq_entry, head_entry;
  logic               empty, full, bypass, enq_fire, deq_fire;

  assign widx = wptr_q[IDX_W-1:0];
  assign ridx = rptr_q[IDX_W-1:0];

  assign empty = (wptr_q == rptr_q);
  assign full  = (widx == ridx) && (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);

  assign is_fetch_q_full = full;
  assign q_count         = wptr_q - rptr_q;

  assign enq_entry  = {enq_inst, enq_pc, enq_pc_next, enq_order, enq_br_pred};
  assign head_entry = mem_q[ridx];

`ifdef FETCH_Q_BYPASS_EN
  assign bypass = empty && enq_valid && !branch_mispredict;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid = !branch_mispredict && (!empty || bypass);
  assign {deq_inst, deq_pc, deq_pc_next, deq_order, deq_br_pred} =
    bypass ? enq_entry : head_entry;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign enq_fire = enq_valid && !full && !branch_mispredict && !(bypass && deq_ready);
  assign deq_fire = !empty && deq_ready && !branch_mispredict;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (branch_mispredict) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (enq_fire) wptr_d = wptr_q + PTR_W'(1);
      if (deq_fire) rptr_d = rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[widx] <= enq_entry;
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Randomised and directed bench for fetch_inst_queue against a queue-based reference model.
module tb_fetch_inst_queue;

  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [63:0] order;
    logic        br_pred;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             branch_mispredict = 1'b0;
  logic             enq_valid = 1'b0;
  logic [31:0]      enq_inst = '0;
  logic [31:0]      enq_pc = '0;
  logic [31:0]      enq_pc_next = '0;
  logic [63:0]      enq_order = '0;
  logic             enq_br_pred = 1'b0;
  logic             is_fetch_q_full;
  logic             deq_ready = 1'b0;
  logic             deq_valid;
  logic [31:0]      deq_inst;
  logic [31:0]      deq_pc;
  logic [31:0]      deq_pc_next;
  logic [63:0]      deq_order;
  logic             deq_br_pred;
  logic [PTR_W-1:0] q_count;

  fetch_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .branch_mispredict(branch_mispredict),
    .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_pc(enq_pc),
    .enq_pc_next(enq_pc_next), .enq_order(enq_order), .enq_br_pred(enq_br_pred),
    .is_fetch_q_full(is_fetch_q_full), .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_inst(deq_inst), .deq_pc(deq_pc), .deq_pc_next(deq_pc_next),
    .deq_order(deq_order), .deq_br_pred(deq_br_pred), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  entry_t model_q[$];
  bit     model_known = 0;

  logic             obs_valid, obs_full;
  logic [PTR_W-1:0] obs_count;
  logic [63:0]      obs_order;
  logic [31:0]      obs_inst, obs_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, compare against the model before the edge, then advance the model.
  task automatic cyc(input bit r, input bit fl, input bit ev, input entry_t e, input bit dr);
    bit     exp_valid, do_deq, do_enq;
    entry_t exp_head;
    @(negedge clk);
    rst = r; branch_mispredict = fl; enq_valid = ev; deq_ready = dr;
    enq_inst = e.inst; enq_pc = e.pc; enq_pc_next = e.pc_next;
    enq_order = e.order; enq_br_pred = e.br_pred;
    #1;
    obs_valid = deq_valid; obs_full = is_fetch_q_full; obs_count = q_count;
    obs_order = deq_order; obs_inst = deq_inst; obs_pc = deq_pc;

    exp_valid = 0;
    exp_head  = e;
    if (model_known) begin
      exp_valid = !fl && (model_q.size() > 0);
`ifdef FETCH_Q_BYPASS_EN
      if (!fl && model_q.size() == 0 && ev) exp_valid = 1;
`endif
      if (model_q.size() > 0) exp_head = model_q[0];
      chk("deq_valid", {63'd0, deq_valid}, {63'd0, exp_valid});
      chk("q_count", {{(64-PTR_W){1'b0}}, q_count}, 64'(model_q.size()));
      chk("full", {63'd0, is_fetch_q_full}, {63'd0, model_q.size() == DEPTH});
      if (exp_valid) begin
        chk("deq_order", deq_order, exp_head.order);
        chk("deq_inst", {32'd0, deq_inst}, {32'd0, exp_head.inst});
        chk("deq_pc", {32'd0, deq_pc}, {32'd0, exp_head.pc});
        chk("deq_pc_next", {32'd0, deq_pc_next}, {32'd0, exp_head.pc_next});
        chk("deq_br_pred", {63'd0, deq_br_pred}, {63'd0, exp_head.br_pred});
      end
    end

    if (r || fl) begin
      model_q.delete();
      if (r) model_known = 1;
    end else if (model_known) begin
      do_deq = exp_valid && dr;
      do_enq = ev && (model_q.size() < DEPTH);
`ifdef FETCH_Q_BYPASS_EN
      if (model_q.size() == 0 && do_enq && dr) begin
        do_deq = 0;
        do_enq = 0;
      end
`endif
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(e);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] pc, input logic [63:0] order);
    entry_t e;
    e.inst    = $urandom;
    e.pc      = pc;
    e.pc_next = pc + 32'd4;
    e.order   = order;
    e.br_pred = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic idle(input bit dr);
    cyc(0, 0, 0, mk(0, 0), dr);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) idle(1);
  endtask

  initial begin
    entry_t e;

    // Reset
    cyc(1, 0, 0, mk(0, 0), 0);
    cyc(1, 0, 0, mk(0, 0), 0);
    idle(0);
    chk("reset_valid", {63'd0, obs_valid}, 64'd0);
    chk("reset_full", {63'd0, obs_full}, 64'd0);
    chk("reset_count", 64'(obs_count), 64'd0);

    // Fill, overflow attempt, drain in order
    for (int k = 0; k < DEPTH; k++) cyc(0, 0, 1, mk(32'h1eceb000 + 32'(4 * k), 64'(k)), 0);
    cyc(0, 0, 1, mk(32'h1eceb040, 64'd16), 0);
    chk("fill_full", {63'd0, obs_full}, 64'd1);
    chk("fill_count", 64'(obs_count), 64'd16);
    for (int k = 0; k < DEPTH; k++) begin
      idle(1);
      chk("drain_valid", {63'd0, obs_valid}, 64'd1);
      chk("drain_order", obs_order, 64'(k));
    end
    idle(0);
    chk("drained_valid", {63'd0, obs_valid}, 64'd0);
    chk("drained_count", 64'(obs_count), 64'd0);

    // Steady state across pointer wrap
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, mk(32'h2000 + 32'(4 * k), 64'(100 + k)), 0);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 1, mk(32'h3000 + 32'(4 * i), 64'(103 + i)), 1);
      chk("steady_count", 64'(obs_count), 64'd3);
      chk("steady_order", obs_order, 64'(100 + i));
    end
    drain();

    // Flush with same-cycle enqueue
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, mk(32'h4000 + 32'(4 * k), 64'(200 + k)), 0);
    cyc(0, 1, 1, mk(32'h4014, 64'd205), 1);
    chk("flush_valid", {63'd0, obs_valid}, 64'd0);
    idle(1);
    chk("post_flush_count", 64'(obs_count), 64'd0);
    chk("post_flush_valid", {63'd0, obs_valid}, 64'd0);
    cyc(0, 0, 1, mk(32'h5000, 64'd206), 0);
    idle(1);
    chk("post_flush_order", obs_order, 64'd206);
    drain();

    // Full with simultaneous dequeue: enqueue still rejected
    for (int k = 0; k < DEPTH; k++) cyc(0, 0, 1, mk(32'h6000 + 32'(4 * k), 64'(300 + k)), 0);
    cyc(0, 0, 1, mk(32'h6040, 64'd316), 1);
    chk("fulldeq_count", 64'(obs_count), 64'd16);
    chk("fulldeq_order", obs_order, 64'd300);
    cyc(0, 0, 1, mk(32'h6044, 64'd317), 0);
    chk("fulldeq_after", 64'(obs_count), 64'd15);
    idle(0);
    chk("refill_count", 64'(obs_count), 64'd16);
    chk("refill_full", {63'd0, obs_full}, 64'd1);
    drain();

    // Empty queue, enqueue with deq_ready
    e = mk(32'h1eceb000, 64'd400);
    e.inst = 32'h00000013;
    cyc(0, 0, 1, e, 1);
`ifdef FETCH_Q_BYPASS_EN
    chk("bypass_valid", {63'd0, obs_valid}, 64'd1);
    chk("bypass_inst", {32'd0, obs_inst}, 64'h13);
    chk("bypass_pc", {32'd0, obs_pc}, 64'h1eceb000);
    chk("bypass_count", 64'(obs_count), 64'd0);
    idle(1);
    chk("bypass_after_count", 64'(obs_count), 64'd0);
    chk("bypass_after_valid", {63'd0, obs_valid}, 64'd0);
`else
    chk("nobypass_valid", {63'd0, obs_valid}, 64'd0);
    idle(1);
    chk("nobypass_next_valid", {63'd0, obs_valid}, 64'd1);
    chk("nobypass_next_inst", {32'd0, obs_inst}, 64'h13);
    chk("nobypass_next_count", 64'(obs_count), 64'd1);
`endif
    drain();

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) < 6, mk($urandom, {$urandom, $urandom}),
          $urandom_range(0, 9) < 5 + (i / 1000));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
